// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 hex keypad scanner with debounce and a 32-bit digit entry register.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE     = 4,
    parameter int REPEAT_SCANS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col,
    output logic [3:0]  row,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [31:0] data
);
    typedef enum logic [1:0] {S_SCAN, S_DEB, S_HOLD} state_t;
    localparam int DW = $clog2(SCAN_DIV);

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    ridx_q, ridx_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [3:0]    code_q, code_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;
    logic [31:0]   data_q, data_d;
    logic [3:0]    sync1_q, scol_q;
    logic          sample, one, same, acc;
    logic [1:0]    cidx;
`ifdef KEYPAD_REPEAT_EN
    logic [15:0]   hold_q, hold_d;
`else
    logic          unused_repeat;
    assign unused_repeat = (REPEAT_SCANS > 0);
`endif

    assign sample    = div_q == DW'(SCAN_DIV - 1);
    assign one       = $onehot(~scol_q);
    assign cidx      = !scol_q[0] ? 2'd0 : !scol_q[1] ? 2'd1 : !scol_q[2] ? 2'd2 : 2'd3;
    assign same      = one && cidx == code_q[1:0];
    assign row       = ~(4'b0001 << ridx_q);
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign data      = data_q;

    // Scan/debounce/hold decisions, taken only at the divider sample point.
    always_comb begin
        state_d = state_q;
        div_d   = sample ? '0 : div_q + 1'b1;
        ridx_d  = ridx_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        acc     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        hold_d  = hold_q;
`endif
        if (sample) begin
            case (state_q)
                S_SCAN: begin
                    if (one) begin
                        code_d = {ridx_q, cidx};
                        cnt_d  = 16'd1;
                        if (DEBOUNCE == 1) begin
                            acc     = 1'b1;
                            state_d = S_HOLD;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_DEB;
                        end
                    end else begin
                        ridx_d = ridx_q + 2'd1;
                    end
                end
                S_DEB: begin
                    if (same) begin
                        cnt_d = cnt_q + 16'd1;
                        if (cnt_d == 16'(DEBOUNCE)) begin
                            acc     = 1'b1;
                            state_d = S_HOLD;
                            cnt_d   = '0;
                        end
                    end else begin
                        state_d = S_SCAN;
                        ridx_d  = ridx_q + 2'd1;
                        cnt_d   = '0;
                    end
                end
                S_HOLD: begin
                    cnt_d = &scol_q ? cnt_q + 16'd1 : '0;
                    if (cnt_d == 16'(DEBOUNCE)) begin
                        state_d = S_SCAN;
                        ridx_d  = ridx_q + 2'd1;
                        cnt_d   = '0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    hold_d = same ? hold_q + 16'd1 : '0;
                    if (hold_d == 16'(REPEAT_SCANS)) begin
                        acc    = 1'b1;
                        hold_d = '0;
                    end
`endif
                end
                default: state_d = S_SCAN;
            endcase
        end
        key_valid_d = acc;
        key_code_d  = acc ? code_d : key_code_q;
        data_d      = acc ? {data_q[27:0], code_d} : data_q;
    end

    // State registers plus the two-flop column synchronizer (idle columns read high).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_SCAN;
            div_q       <= '0;
            ridx_q      <= '0;
            cnt_q       <= '0;
            code_q      <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            data_q      <= '0;
            sync1_q     <= 4'hF;
            scol_q      <= 4'hF;
`ifdef KEYPAD_REPEAT_EN
            hold_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            ridx_q      <= ridx_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            data_q      <= data_d;
            sync1_q     <= col;
            scol_q      <= sync1_q;
`ifdef KEYPAD_REPEAT_EN
            hold_q      <= hold_d;
`endif
        end
    end
endmodule
